// File: rtl/fir_feed_pkg.sv
// Shared definitions for the FIR sample feeder.
// Holds the frame-sequencer state encoding (also decoded by the APB register
// block for status readback), the counter width and the flush-length helper.
package fir_feed_pkg;

  localparam int FEED_CW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } feed_state_t;

  // Number of zero samples needed to drain the delay line: tap count is
  // clamped to [1, max_taps], and the flush length is one less than that.
  function automatic logic [FEED_CW-1:0] flush_count(
    input logic [3:0]         ntaps,
    input logic [FEED_CW-1:0] max_taps
  );
    logic [FEED_CW-1:0] taps;
    taps = {{(FEED_CW-4){1'b0}}, ntaps};
    if (taps > max_taps) begin
      taps = max_taps;
    end else if (taps == {FEED_CW{1'b0}}) begin
      taps = {{(FEED_CW-1){1'b0}}, 1'b1};
    end else begin
      taps = taps;
    end
    return taps - {{(FEED_CW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Input sample stream (valid/ready) between the front-end and the feeder.
//   i_s_valid : sample valid (front-end -> feeder)
//   i_s_data  : sample value (front-end -> feeder)
//   o_s_ready : feeder can accept a sample (feeder -> front-end)
interface fir_sample_feeder_if #(
  parameter int IW = 12
);
  logic          i_s_valid;
  logic [IW-1:0] i_s_data;
  logic          o_s_ready;

  modport master (output i_s_valid, output i_s_data, input o_s_ready);
  modport slave  (input i_s_valid, input i_s_data, output o_s_ready);
endinterface

// File: rtl/fir_feed_fifo.sv
// Synchronous FIFO buffering input samples for the feeder.
//   clk_i/rst_ni : clock, async active-low reset
//   flush_i      : empty the FIFO; overrides push and pop in the same cycle
//   push_i/data_i: write request and data (refused while full)
//   pop_i/data_o : read request; data_o shows the head word combinationally
//   full_o/empty_o/level_o : registered status
module fir_feed_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          full_q;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;

  // Full is registered, so a pop in the full cycle does not free a slot for a push.
  assign empty_s = (level_q == {LW{1'b0}});
  assign push_s  = push_i && !full_q && !flush_i;
  assign pop_s   = pop_i && !empty_s && !flush_i;

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_s;
  assign level_o = level_q;

  // Occupancy next-state from the accepted push/pop pair.
  always_comb begin
    level_d = level_q;
    if (push_s && !pop_s) begin
      level_d = level_q + LVL_ONE;
    end else if (pop_s && !push_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end
  end

  // Pointer, occupancy and full-flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      full_q   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      full_q   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
    end
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Sample-side initiator for the FIR tap chain. Buffers pushed samples and, per
// frame, feeds sig_len data samples then max(ntaps,1)-1 zeros to the filter.
//   i_clk/i_reset_n      : clock, async active-low reset
//   i_start/i_abort      : frame start pulse / abort and FIFO flush
//   i_sig_len/i_ntaps    : frame length and tap count, latched on start
//   s_if (slave)         : input sample stream
//   o_fir_ce/o_fir_sample: filter enable and sample (sample is 0 when ce is 0)
//   o_fir_clr            : one-cycle filter clear (frame start or abort)
//   o_busy/o_done/o_level: frame active, completion pulse, FIFO occupancy
module fir_sample_feeder
  import fir_feed_pkg::*;
#(
  parameter int IW    = 12,
  parameter int NTAPS = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [15:0]            i_sig_len,
  input  logic [3:0]             i_ntaps,
  fir_sample_feeder_if.slave     s_if,
  output logic                   o_fir_ce,
  output logic [IW-1:0]          o_fir_sample,
  output logic                   o_fir_clr,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam logic [FEED_CW-1:0] CNT_ONE  = FEED_CW'(1);
  localparam logic [FEED_CW-1:0] MAX_TAPS = FEED_CW'(NTAPS);

  feed_state_t        state_q, state_d;
  logic [FEED_CW-1:0] cnt_q, cnt_d;      // data pops left in FEED, zeros left in FLUSH
  logic [FEED_CW-1:0] flush_q, flush_d;  // flush length latched at start
  logic               ce_d, clr_d, done_d;
  logic [IW-1:0]      sample_d;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [IW-1:0]      fifo_data_s;

  fir_feed_fifo #(.W(IW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .flush_i (i_abort),
    .push_i  (s_if.i_s_valid),
    .data_i  (s_if.i_s_data),
    .pop_i   (pop_s),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (o_level)
  );

  assign s_if.o_s_ready = !fifo_full_s;

  // Frame sequencer next-state and registered-output next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    pop_s    = 1'b0;
    ce_d     = 1'b0;
    sample_d = {IW{1'b0}};
    clr_d    = 1'b0;
    done_d   = 1'b0;
    if (i_abort) begin
      // Abort wins over start; only an active frame needs the filter cleared.
      state_d = IDLE;
      cnt_d   = {FEED_CW{1'b0}};
      clr_d   = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d = CLEAR;
            cnt_d   = i_sig_len;
            flush_d = flush_count(i_ntaps, MAX_TAPS);
            clr_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        CLEAR: begin
          if (cnt_q != {FEED_CW{1'b0}}) begin
            state_d = FEED;
          end else if (flush_q != {FEED_CW{1'b0}}) begin
            state_d = FLUSH;
            cnt_d   = flush_q;
          end else begin
            state_d = DONE;
          end
        end
        FEED: begin
          if (!fifo_empty_s) begin
            pop_s    = 1'b1;
            ce_d     = 1'b1;
            sample_d = fifo_data_s;
            cnt_d    = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              // Last data word: go straight into the zero flush with no bubble.
              if (flush_q != {FEED_CW{1'b0}}) begin
                state_d = FLUSH;
                cnt_d   = flush_q;
              end else begin
                state_d = DONE;
              end
            end else begin
              state_d = FEED;
            end
          end else begin
            state_d = FEED;
          end
        end
        FLUSH: begin
          ce_d  = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end else begin
            state_d = FLUSH;
          end
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and all filter-facing outputs are registered.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= {FEED_CW{1'b0}};
      flush_q      <= {FEED_CW{1'b0}};
      o_fir_ce     <= 1'b0;
      o_fir_sample <= {IW{1'b0}};
      o_fir_clr    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      o_fir_ce     <= ce_d;
      o_fir_sample <= sample_d;
      o_fir_clr    <= clr_d;
      o_busy       <= (state_d != IDLE);
      o_done       <= done_d;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;
  localparam int IW = 12;
  localparam int NTAPS = 8;
  localparam int DEPTH = 16;

  typedef struct {
    int sl; int nt; int npre; int gap; int dbase; int exp_ce;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [15:0] sig_len = 16'd0;
  logic [3:0] ntaps = 4'd0;
  logic ce, clr, busy, done;
  logic [IW-1:0] sample;
  logic [4:0] level;
  int errs = 0;
  int checks = 0;
  vec_t vecs[7];

  fir_sample_feeder_if #(.IW(IW)) s_if();

  fir_sample_feeder #(.IW(IW), .NTAPS(NTAPS), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
    .i_sig_len(sig_len), .i_ntaps(ntaps), .s_if(s_if),
    .o_fir_ce(ce), .o_fir_sample(sample), .o_fir_clr(clr),
    .o_busy(busy), .o_done(done), .o_level(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full frame: optional preload, start, paced pushes, collect ce stream.
  task automatic run_frame(input string nm, input int sl, input int nt, input int npre,
                           input int gap, input int dbase, input int exp_ce);
    logic [IW-1:0] pushed[$];
    logic [IW-1:0] got[$];
    int ce_cyc[$];
    int eff, nexp, pushes, done_n, done_cyc, nxt, budget, k0;
    logic fin;
    logic [IW-1:0] d;
    eff = (nt == 0) ? 1 : ((nt > NTAPS) ? NTAPS : nt);
    nexp = (exp_ce >= 0) ? exp_ce : (sl + eff - 1);
    for (int i = 0; i < npre; i++) begin
      d = (dbase != 0) ? IW'(dbase + i) : IW'($urandom);
      pushed.push_back(d);
      s_if.i_s_valid = 1'b1;
      s_if.i_s_data = d;
      tick();
    end
    s_if.i_s_valid = 1'b0;
    pushes = npre;
    chk({nm, "_preload_level"}, 32'(level), 32'(npre));
    sig_len = 16'(sl);
    ntaps = 4'(nt);
    start = 1'b1;
    tick();
    chk({nm, "_clr_first"}, 32'(clr), 32'd1);
    chk({nm, "_busy_first"}, 32'(busy), 32'd1);
    chk({nm, "_ce_in_clr"}, 32'(ce), 32'd0);
    // Changing frame parameters after start must not matter.
    sig_len = 16'($urandom);
    ntaps = 4'($urandom);
    fin = 1'b0; done_n = 0; done_cyc = -1; nxt = 1;
    budget = sl * (gap + 2) + 40;
    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      start = (cyc == 1);  // a second start while busy is ignored
      if (pushes < sl && s_if.o_s_ready && cyc >= nxt) begin
        d = (dbase != 0) ? IW'(dbase + pushes) : IW'($urandom);
        pushed.push_back(d);
        pushes++;
        nxt = cyc + gap + 1;
        s_if.i_s_valid = 1'b1;
        s_if.i_s_data = d;
      end else begin
        s_if.i_s_valid = 1'b0;
      end
      tick();
      if (ce) begin
        got.push_back(sample);
        ce_cyc.push_back(cyc);
      end else begin
        chk({nm, "_idle_sample_zero"}, 32'(sample), 32'd0);
      end
      chk({nm, "_clr_later"}, 32'(clr), 32'd0);
      if (done_n > 0 && cyc == done_cyc + 1) begin
        chk({nm, "_busy_after_done"}, 32'(busy), 32'd0);
        fin = 1'b1;
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    s_if.i_s_valid = 1'b0;
    start = 1'b0;
    if (!fin) begin
      checks++; errs++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, budget);
    end
    chk({nm, "_done_count"}, 32'(done_n), 32'd1);
    chk({nm, "_ce_count"}, 32'(got.size()), 32'(nexp));
    for (int k = 0; k < got.size() && k < nexp; k++)
      chk({nm, "_ce_data"}, 32'(got[k]), 32'((k < sl) ? pushed[k] : '0));
    if (got.size() > 0)
      chk({nm, "_done_after_last_ce"}, 32'(done_cyc), 32'(ce_cyc[got.size()-1] + 1));
    else
      chk({nm, "_done_no_ce"}, 32'(done_cyc), 32'd2);
    k0 = (sl > 1) ? sl : 1;
    if (npre == sl && got.size() > 0) begin
      chk({nm, "_first_ce_cycle"}, 32'(ce_cyc[0]), 32'd2);
      k0 = 1;
    end
    for (int k = k0; k < got.size(); k++)
      chk({nm, "_ce_contiguous"}, 32'(ce_cyc[k]), 32'(ce_cyc[k-1] + 1));
    chk({nm, "_level_end"}, 32'(level), 32'd0);
  endtask

  initial begin
    int sl, nt, np, gp;
    s_if.i_s_valid = 1'b0;
    s_if.i_s_data = '0;
    vecs[0] = '{sl: 4,  nt: 3,  npre: 4,  gap: 0, dbase: 1,  exp_ce: 6};
    vecs[1] = '{sl: 0,  nt: 1,  npre: 0,  gap: 0, dbase: 0,  exp_ce: 0};
    vecs[2] = '{sl: 1,  nt: 12, npre: 1,  gap: 0, dbase: 0,  exp_ce: 8};
    vecs[3] = '{sl: 5,  nt: 0,  npre: 2,  gap: 3, dbase: 0,  exp_ce: 5};
    vecs[4] = '{sl: 6,  nt: 8,  npre: 0,  gap: 1, dbase: 0,  exp_ce: 13};
    vecs[5] = '{sl: 3,  nt: 15, npre: 3,  gap: 0, dbase: 0,  exp_ce: 10};
    vecs[6] = '{sl: 10, nt: 4,  npre: 10, gap: 0, dbase: 40, exp_ce: 13};

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(s_if.o_s_ready), 32'd1);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_clr", 32'(clr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].sl, vecs[v].nt, vecs[v].npre,
                vecs[v].gap, vecs[v].dbase, vecs[v].exp_ce);

    // Samples arriving with gaps: ce exactly one cycle after each pop.
    sig_len = 16'd3; ntaps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      s_if.i_s_valid = 1'b1; s_if.i_s_data = IW'(5 + s);
      tick();
      s_if.i_s_valid = 1'b0;
      chk("gap_ce_low", 32'(ce), 32'd0);
      tick();
      chk("gap_ce_high", 32'(ce), 32'd1);
      chk("gap_data", 32'(sample), 32'(5 + s));
      tick();
      chk("gap_after_ce", 32'(ce), (s < 2) ? 32'd0 : 32'd1);
      if (s == 2) chk("gap_flush_zero", 32'(sample), 32'd0);
    end
    tick();
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_done_ce", 32'(ce), 32'd0);
    tick();
    chk("gap_done_pulse", 32'(done), 32'd0);
    chk("gap_busy_end", 32'(busy), 32'd0);

    // Overflow with no frame running.
    for (int i = 1; i <= 17; i++) begin
      chk("ovf_ready", 32'(s_if.o_s_ready), (i <= 16) ? 32'd1 : 32'd0);
      s_if.i_s_valid = 1'b1; s_if.i_s_data = IW'(i);
      tick();
    end
    s_if.i_s_valid = 1'b0;
    chk("ovf_level", 32'(level), 32'd16);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_level", 32'(level), 32'd0);
    chk("idle_abort_clr", 32'(clr), 32'd0);
    chk("idle_abort_ready", 32'(s_if.o_s_ready), 32'd1);

    // Abort during FEED after 2 of 5 samples, with a same-cycle push.
    for (int i = 0; i < 2; i++) begin
      s_if.i_s_valid = 1'b1; s_if.i_s_data = IW'(9 + i);
      tick();
    end
    s_if.i_s_valid = 1'b0;
    sig_len = 16'd5; ntaps = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("abt_fed_two", 32'(ce), 32'd0);
    chk("abt_busy_before", 32'(busy), 32'd1);
    abort = 1'b1; start = 1'b1;
    s_if.i_s_valid = 1'b1; s_if.i_s_data = IW'(77);
    tick();
    abort = 1'b0; start = 1'b0; s_if.i_s_valid = 1'b0;
    chk("abt_ce", 32'(ce), 32'd0);
    chk("abt_clr", 32'(clr), 32'd1);
    chk("abt_level", 32'(level), 32'd0);
    chk("abt_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abt_no_done", 32'(done), 32'd0);
      chk("abt_no_ce", 32'(ce), 32'd0);
    end
    run_frame("after_abort", 3, 2, 3, 0, 0, 4);

    // Asynchronous reset in the middle of FLUSH.
    s_if.i_s_valid = 1'b1; s_if.i_s_data = IW'(3);
    tick();
    s_if.i_s_valid = 1'b0;
    sig_len = 16'd1; ntaps = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rstflush_ce_before", 32'(ce), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstflush_ce", 32'(ce), 32'd0);
    chk("rstflush_clr", 32'(clr), 32'd0);
    chk("rstflush_busy", 32'(busy), 32'd0);
    chk("rstflush_done", 32'(done), 32'd0);
    chk("rstflush_ready", 32'(s_if.o_s_ready), 32'd1);
    chk("rstflush_level", 32'(level), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized frames against the arithmetic model in run_frame.
    for (int r = 0; r < 8; r++) begin
      sl = $urandom_range(0, 24);
      nt = $urandom_range(0, 15);
      np = $urandom_range(0, (sl < DEPTH) ? sl : DEPTH);
      gp = $urandom_range(0, 3);
      run_frame($sformatf("rand%0d", r), sl, nt, np, gp, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
